// File: rtl/neuron_feeder.sv
// Collects N (weight, input) pairs, fires a one-cycle neuron enable, waits LAT cycles
// for the result and hands it downstream. Optional NEURON_FEEDER_CNT_EN adds done_cnt_o.
module neuron_feeder #(
    parameter int N   = 4,
    parameter int W   = 16,
    parameter int LAT = 2
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           flush_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [W-1:0]   weight_i,
    input  logic [W-1:0]   x_i,
    output logic           en_o,
    output logic [N*W-1:0] weights_o,
    output logic [N*W-1:0] x_o,
    input  logic [W-1:0]   result_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [W-1:0]   out_data_o
`ifdef NEURON_FEEDER_CNT_EN
    ,
    output logic [15:0]    done_cnt_o
`endif
);

    localparam int IW = $clog2(N);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

    typedef enum logic [1:0] {LOAD, FIRE, WAIT, OUT} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       waitCnt_q, waitCnt_d;
    logic [N-1:0][W-1:0] weightVec_q;
    logic [N-1:0][W-1:0] inputVec_q;
    logic [W-1:0]        result_q;
    logic                transfer;
    logic                capture;
    logic                handshake;

    // Flush wins over every other transition, including a pending load or handshake.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        waitCnt_d   = waitCnt_q;
        capture     = 1'b0;
        in_ready_o  = (state_q == LOAD);
        en_o        = (state_q == FIRE);
        out_valid_o = (state_q == OUT) && !flush_i;
        transfer    = in_ready_o && in_valid_i && !flush_i;
        handshake   = out_valid_o && out_ready_i;

        case (state_q)
            LOAD: begin
                if (transfer) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = FIRE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            FIRE: begin
                state_d   = WAIT;
                waitCnt_d = CNT_LOAD;
            end
            WAIT: begin
                if (waitCnt_q == '0) begin
                    capture = 1'b1;
                    state_d = OUT;
                end else begin
                    waitCnt_d = waitCnt_q - CW'(1);
                end
            end
            OUT: begin
                if (handshake) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase

        if (flush_i) begin
            state_d   = LOAD;
            idx_d     = '0;
            waitCnt_d = '0;
            capture   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= LOAD;
            idx_q     <= '0;
            waitCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    // Vectors change only on accepted pairs, so the neuron sees them stable from FIRE onwards.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            weightVec_q <= '0;
            inputVec_q  <= '0;
            result_q    <= '0;
        end else begin
            if (transfer) begin
                weightVec_q[idx_q] <= weight_i;
                inputVec_q[idx_q]  <= x_i;
            end
            if (capture) begin
                result_q <= result_i;
            end
        end
    end

    assign weights_o  = weightVec_q;
    assign x_o        = inputVec_q;
    assign out_data_o = result_q;

`ifdef NEURON_FEEDER_CNT_EN
    logic [15:0] doneCnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            doneCnt_q <= '0;
        end else if (handshake) begin
            doneCnt_q <= doneCnt_q + 16'd1;
        end
    end

    assign done_cnt_o = doneCnt_q;
`endif

endmodule

// File: doc/neuron_feeder.md
NEURON_FEEDER -- requirements
Module: neuron_feeder

Interface
REQ-001 The module SHALL have parameter N, default neuron_size, meaning the number of inputs per neuron (N >= 2).
REQ-002 The module SHALL have parameter W, default word_size, meaning the bit width of each weight, input and result word.
REQ-003 The module SHALL have parameter LAT, default 2, meaning the neuron compute latency in cycles (LAT >= 1).
REQ-004 The module SHALL use a single clock and an asynchronous, active-low reset, named as in the codebase (ports listed first, below).
REQ-005 The module SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous reset, active low
- flush_i  in  1  synchronous abort
- in_valid_i  in  1  upstream pair valid
- in_ready_o  out  1  upstream pair accepted
- weight_i  in  W  weight word
- x_i  in  W  input word
- en_o  out  1  neuron enable, one-cycle pulse
- weights_o  out  N*W  packed weight vector, slot k at bits [k*W +: W]
- x_o  out  N*W  packed input vector, same packing as weights_o
- result_i  in  W  neuron result
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream ready
- out_data_o  out  W  captured result

Function
REQ-006 The FSM SHALL have exactly four states, LOAD, FIRE, WAIT and OUT, and SHALL enter LOAD on reset.
REQ-007 In LOAD:
- in_ready_o = 1.
- A transfer is in_valid_i & in_ready_o.
- Each transfer SHALL write weight_i and x_i into slot idx, then increment idx.
REQ-008 On the transfer with idx = N-1, the FSM SHALL go to FIRE, and idx SHALL return to 0.
REQ-009 In FIRE, en_o SHALL be 1 for exactly one cycle, after which the FSM SHALL go to WAIT; en_o SHALL be 0 in all other states.
REQ-010 weights_o and x_o SHALL be driven directly from registers and SHALL be written only by LOAD transfers, so they are stable from FIRE until the next transfer.
REQ-011 WAIT SHALL last LAT cycles, set by a down-counter.
REQ-012 result_i SHALL be sampled into the result register on the clock edge exactly LAT cycles after the edge that sampled en_o = 1; the FSM SHALL then go to OUT.
REQ-013 Latency: if the last pair is accepted in cycle T, then en_o = 1 in cycle T+1 and out_valid_o first = 1 in cycle T+2+LAT.
REQ-014 In OUT:
- out_valid_o = 1 and out_data_o = result register, held stable until out_ready_i = 1.
- On out_valid_o & out_ready_i, the FSM SHALL go to LOAD.
REQ-015 Outside LOAD, in_ready_o SHALL be 0; no pair is accepted during FIRE, WAIT or OUT.
REQ-016 out_data_o SHALL keep its last captured value outside OUT.
REQ-017 Arithmetic: idx SHALL be $clog2(N) bits wide and SHALL never exceed N-1; no wrap-around beyond N-1 is permitted.
REQ-018 flush_i = 1 SHALL force, in every state, next state = LOAD, idx = 0, WAIT counter = 0 and out_valid_o = 0.
REQ-019 flush_i SHALL leave the vector and result registers unchanged.
REQ-020 flush_i SHALL take priority over a simultaneous input transfer (pair dropped) and over a simultaneous output handshake (result dropped).

Reset
REQ-021 While rst_n_i = 0, asynchronously:
- state = LOAD, idx = 0, WAIT counter = 0;
- en_o = 0, out_valid_o = 0, in_ready_o = 1;
- weights_o, x_o and out_data_o all zero.
REQ-022 Reset asserted mid-operation SHALL discard any partial load or pending result, with no output pulse afterwards.
REQ-023 Reset deassertion SHALL be synchronised externally; the first transfer can occur on the first rising edge after release.

Configuration
REQ-024 With NEURON_FEEDER_CNT_EN defined, the module SHALL add the following ports and behaviour:
- output done_cnt_o, 16 bits, reset 0;
- done_cnt_o increments on each out_valid_o & out_ready_i handshake and wraps from 65535 to 0;
- done_cnt_o is unaffected by flush_i.
REQ-025 Without NEURON_FEEDER_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification (N=4, W=16, LAT=2; bench neuron model: result_i = sum of weight*x, LAT cycles after en_o)
REQ-026 Four back-to-back pairs (2,1) -> en_o pulses once in T+1, weights_o = {2,2,2,2}, x_o = {1,1,1,1}, out_valid_o in T+4 with out_data_o = 8.
REQ-027 in_valid_i toggling every other cycle with pairs (1,1),(2,2),(3,3),(4,4) -> only accepted pairs are loaded, slot order 0..3, out_data_o = 30.
REQ-028 out_ready_i held 0 for 5 cycles in OUT, plus in_valid_i = 1 -> out_valid_o and out_data_o stable, in_ready_o = 0, no pair lost; after the handshake the next pair goes to slot 0.
REQ-029 flush_i after 2 pairs, and flush_i together with the output handshake -> idx = 0, no en_o pulse, no out_valid_o, next 4 pairs produce a correct result.
REQ-030 rst_n_i low during WAIT -> immediate reset values, no out_valid_o afterwards; with NEURON_FEEDER_CNT_EN, done_cnt_o = 0 after reset and 3 after 3 completed handshakes.
